// File: rtl/tdm_pkg.sv
// rtl/tdm_pkg.sv - shared state encoding and limits for the TDM demultiplexer
package tdm_pkg;

  typedef enum logic {
    ST_HUNT   = 1'b0,
    ST_LOCKED = 1'b1
  } tdm_state_e;

  localparam int MAX_CH    = 16;
  localparam int ERR_CNT_W = 16;

endpackage

// File: rtl/tdm_ch_reg.sv
// rtl/tdm_ch_reg.sv - one channel output: load-enable data register plus one-cycle valid pulse
module tdm_ch_reg #(
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic [DATA_W-1:0] d,
  output logic [DATA_W-1:0] q,
  output logic              valid
);

  always_ff @(posedge clk) begin
    if (rst) begin
      q     <= '0;
      valid <= 1'b0;
    end else begin
      valid <= load;
      if (load) q <= d;
    end
  end

endmodule

// File: rtl/tdm_demux_1_n.sv
// rtl/tdm_demux_1_n.sv - 1:N TDM demux with HUNT/LOCKED frame alignment
// Optional: define TDM_DEMUX_ERR_CNT_EN to add a saturating err_count output.
module tdm_demux_1_n
  import tdm_pkg::*;
#(
  parameter int NUM_CH = 4,
  parameter int DATA_W = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  input  logic                     in_sync,
  input  logic [DATA_W-1:0]        in_data,
  output logic [NUM_CH*DATA_W-1:0] ch_data,
  output logic [NUM_CH-1:0]        ch_valid,
  output logic                     frame_done,
  output logic                     locked,
  output logic                     sync_err
`ifdef TDM_DEMUX_ERR_CNT_EN
  ,
  output logic [ERR_CNT_W-1:0]     err_count
`endif
);

  localparam int IDX_W = $clog2(NUM_CH);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_CH - 1);
  localparam logic [IDX_W-1:0] ONE_IDX  = IDX_W'(1);

  tdm_state_e        state, nxt_state;
  logic [IDX_W-1:0]  ch_idx, nxt_idx;
  logic [NUM_CH-1:0] wr_en;
  logic              nxt_done, nxt_err;

  always_comb begin
    nxt_state = state;
    nxt_idx   = ch_idx;
    wr_en     = '0;
    nxt_done  = 1'b0;
    nxt_err   = 1'b0;
    if (in_valid) begin
      if (state == ST_HUNT) begin
        if (in_sync) begin
          wr_en[0]  = 1'b1;
          nxt_idx   = ONE_IDX;
          nxt_state = ST_LOCKED;
        end
      end else if (ch_idx == '0) begin
        if (in_sync) begin
          wr_en[0] = 1'b1;
          nxt_idx  = ONE_IDX;
        end else begin
          nxt_err   = 1'b1;
          nxt_state = ST_HUNT;
        end
      end else if (in_sync) begin
        // Early sync: resynchronise on this beat, abandoning the partial frame.
        nxt_err  = 1'b1;
        wr_en[0] = 1'b1;
        nxt_idx  = ONE_IDX;
      end else begin
        wr_en[ch_idx] = 1'b1;
        nxt_done      = (ch_idx == LAST_IDX);
        nxt_idx       = (ch_idx == LAST_IDX) ? '0 : ch_idx + ONE_IDX;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= ST_HUNT;
      ch_idx     <= '0;
      locked     <= 1'b0;
      frame_done <= 1'b0;
      sync_err   <= 1'b0;
    end else begin
      state      <= nxt_state;
      ch_idx     <= nxt_idx;
      locked     <= (nxt_state == ST_LOCKED);
      frame_done <= nxt_done;
      sync_err   <= nxt_err;
    end
  end

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    tdm_ch_reg #(.DATA_W(DATA_W)) u_ch_reg (
      .clk   (clk),
      .rst   (rst),
      .load  (wr_en[i]),
      .d     (in_data),
      .q     (ch_data[i*DATA_W +: DATA_W]),
      .valid (ch_valid[i])
    );
  end

`ifdef TDM_DEMUX_ERR_CNT_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      err_count <= '0;
    end else if (nxt_err && (err_count != '1)) begin
      err_count <= err_count + 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_tdm_demux_1_n.sv
// tb/tb_tdm_demux_1_n.sv - randomized self-checking bench for tdm_demux_1_n against a frame-level model
module tb_tdm_demux_1_n;

  localparam int NUM_CH = 4;
  localparam int DATA_W = 8;

  logic                     clk = 1'b0;
  logic                     rst;
  logic                     in_valid;
  logic                     in_sync;
  logic [DATA_W-1:0]        in_data;
  logic [NUM_CH*DATA_W-1:0] ch_data;
  logic [NUM_CH-1:0]        ch_valid;
  logic                     frame_done;
  logic                     locked;
  logic                     sync_err;
`ifdef TDM_DEMUX_ERR_CNT_EN
  logic [15:0]              err_count;
`endif

  always #5 clk = ~clk;

  tdm_demux_1_n #(.NUM_CH(NUM_CH), .DATA_W(DATA_W)) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_sync    (in_sync),
    .in_data    (in_data),
    .ch_data    (ch_data),
    .ch_valid   (ch_valid),
    .frame_done (frame_done),
    .locked     (locked),
    .sync_err   (sync_err)
`ifdef TDM_DEMUX_ERR_CNT_EN
    ,
    .err_count  (err_count)
`endif
  );

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: frame position counts channels already delivered in this frame.
  bit               m_locked;
  int               m_pos;
  logic [DATA_W-1:0] m_data [NUM_CH];
  int               m_errs;
  logic [NUM_CH-1:0] e_valid;
  bit               e_done;
  bit               e_err;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [NUM_CH*DATA_W-1:0] model_bus();
    logic [NUM_CH*DATA_W-1:0] b;
    for (int i = 0; i < NUM_CH; i++) b[i*DATA_W +: DATA_W] = m_data[i];
    return b;
  endfunction

  task automatic model_reset();
    m_locked = 0;
    m_pos    = 0;
    m_errs   = 0;
    e_valid  = '0;
    e_done   = 0;
    e_err    = 0;
    for (int i = 0; i < NUM_CH; i++) m_data[i] = '0;
  endtask

  task automatic model_beat(input bit v, input bit s, input logic [DATA_W-1:0] d);
    e_valid = '0;
    e_done  = 0;
    e_err   = 0;
    if (!v) return;
    if (!m_locked) begin
      if (s) begin
        m_data[0] = d; e_valid[0] = 1'b1; m_pos = 1; m_locked = 1;
      end
    end else if (s) begin
      e_err = (m_pos != 0);
      m_data[0] = d; e_valid[0] = 1'b1; m_pos = 1;
    end else if (m_pos == 0) begin
      e_err = 1; m_locked = 0;
    end else begin
      m_data[m_pos] = d; e_valid[m_pos] = 1'b1; m_pos++;
      if (m_pos == NUM_CH) begin
        e_done = 1; m_pos = 0;
      end
    end
    if (e_err && m_errs < 16'hFFFF) m_errs++;
  endtask

  task automatic check_outputs(input string tag);
    check({tag, ".ch_data"},    64'(ch_data),    64'(model_bus()));
    check({tag, ".ch_valid"},   64'(ch_valid),   64'(e_valid));
    check({tag, ".frame_done"}, 64'(frame_done), 64'(e_done));
    check({tag, ".locked"},     64'(locked),     64'(m_locked));
    check({tag, ".sync_err"},   64'(sync_err),   64'(e_err));
`ifdef TDM_DEMUX_ERR_CNT_EN
    check({tag, ".err_count"},  64'(err_count),  64'(m_errs));
`endif
  endtask

  task automatic beat(input string tag, input bit v, input bit s, input logic [DATA_W-1:0] d);
    in_valid = v;
    in_sync  = s;
    in_data  = d;
    model_beat(v, s, d);
    @(posedge clk);
    #1;
    check_outputs(tag);
  endtask

  task automatic do_reset(input string tag, input int cycles, input bit v, input logic [DATA_W-1:0] d);
    rst      = 1'b1;
    in_valid = v;
    in_sync  = 1'b0;
    in_data  = d;
    repeat (cycles) @(posedge clk);
    #1;
    rst = 1'b0;
    model_reset();
    check_outputs(tag);
  endtask

  initial begin
    rst = 1'b0; in_valid = 1'b0; in_sync = 1'b0; in_data = '0;
    model_reset();
    #2;

    do_reset("t1_reset", 2, 1'b0, 8'h00);
    beat("t1_idle", 0, 0, 8'h5A);

    beat("t2_b0", 1, 1, 8'h11);
    beat("t2_b1", 1, 0, 8'h22);
    beat("t2_b2", 1, 0, 8'h33);
    beat("t2_b3", 1, 0, 8'h44);

    do_reset("t3_reset", 1, 1'b0, 8'h00);
    beat("t3_aa", 1, 0, 8'hAA);
    beat("t3_bb", 1, 0, 8'hBB);
    beat("t3_sync", 1, 1, 8'h11);

    beat("t4_b1", 1, 0, 8'h22);
    beat("t4_early", 1, 1, 8'h55);
    beat("t4_b1b", 1, 0, 8'h66);
    beat("t4_b2b", 1, 0, 8'h77);
    beat("t4_b3b", 1, 0, 8'h88);

    beat("t5_nosync", 1, 0, 8'h99);
    beat("t5_after", 0, 0, 8'h00);

    beat("t6_b0", 1, 1, 8'h01);
    beat("t6_gap0", 0, 0, 8'hEE);
    beat("t6_b1", 1, 0, 8'h02);
    beat("t6_gap1", 0, 1, 8'hEF);
    do_reset("t6_rst_ch2", 1, 1'b1, 8'h03);
    beat("t6_hunt", 1, 0, 8'h04);

    for (int i = 0; i < 600; i++) begin
      bit v, s;
      v = ($urandom_range(0, 9) != 0);
      s = ($urandom_range(0, 4) == 0);
      if ($urandom_range(0, 199) == 0)
        do_reset("rnd_rst", 1, v, 8'($urandom));
      else
        beat("rnd", v, s, 8'($urandom));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
